// File: rtl/debounce_edge_multi.sv
// debounce_edge_multi: multi-channel switch/key debouncer.
// Each channel is polarity-normalised, synchronised, debounced, and emits a
// one-cycle rise/fall pulse when its debounced level flips. any_edge is the
// registered OR of all edge pulses, aligned with them.
// Optional feature macro: DEBOUNCE_REPEAT_EN enables per-channel hold-repeat
// pulses. Without it repeat_pulse is tied to 0 and no hold counters exist.
module debounce_edge_multi #(
  parameter int                      NUM_SWITCHES    = 22,
  parameter int                      DELAY_COUNTS    = 2500,
  parameter int                      SYNC_STAGES     = 2,
  parameter logic [NUM_SWITCHES-1:0] ACTIVE_LOW_MASK = {NUM_SWITCHES{1'b0}},
  parameter int                      REPEAT_DELAY    = 25000000,
  parameter int                      REPEAT_PERIOD   = 5000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_SWITCHES-1:0] button,
  output logic [NUM_SWITCHES-1:0] button_pressed,
  output logic [NUM_SWITCHES-1:0] rise_pulse,
  output logic [NUM_SWITCHES-1:0] fall_pulse,
  output logic [NUM_SWITCHES-1:0] repeat_pulse,
  output logic                    any_edge
);

  localparam int              CNT_W    = $clog2(DELAY_COUNTS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_COUNTS - 1);

  // Reject configurations the channel logic cannot represent.
  generate
    if (NUM_SWITCHES < 1 || DELAY_COUNTS < 1 || SYNC_STAGES < 2 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("debounce_edge_multi: illegal parameter combination");
    end
  endgenerate

  // Normalised raw level: 1 always means pressed/on.
  logic [NUM_SWITCHES-1:0] norm;
  logic [NUM_SWITCHES-1:0] rise_d;
  logic [NUM_SWITCHES-1:0] fall_d;
  logic                    any_edge_q;

  assign norm = button ^ ACTIVE_LOW_MASK;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SWITCHES; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   sync_out;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   pressed_q, pressed_d;
      logic                   rise_q, fall_q;
      logic                   ch_rise_d, ch_fall_d;

      assign sync_out = sync_q[SYNC_STAGES-1];

      // Shift the normalised input through the synchroniser chain.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], norm[gi]};
        end
      end

      // Count consecutive differing cycles; flip the level on the last one.
      always_comb begin
        cnt_d     = '0;
        pressed_d = pressed_q;
        ch_rise_d = 1'b0;
        ch_fall_d = 1'b0;
        if (sync_out != pressed_q) begin
          if (cnt_q == CNT_LAST) begin
            pressed_d = sync_out;
            ch_rise_d = sync_out;
            ch_fall_d = ~sync_out;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Register counter, debounced level and edge pulses.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt_q     <= '0;
          pressed_q <= 1'b0;
          rise_q    <= 1'b0;
          fall_q    <= 1'b0;
        end else begin
          cnt_q     <= cnt_d;
          pressed_q <= pressed_d;
          rise_q    <= ch_rise_d;
          fall_q    <= ch_fall_d;
        end
      end

      assign rise_d[gi]         = ch_rise_d;
      assign fall_d[gi]         = ch_fall_d;
      assign button_pressed[gi] = pressed_q;
      assign rise_pulse[gi]     = rise_q;
      assign fall_pulse[gi]     = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
      localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
      localparam logic [HOLD_W-1:0] FIRST_LAST = HOLD_W'(REPEAT_DELAY - 1);
      localparam logic [HOLD_W-1:0] NEXT_LAST  = HOLD_W'(REPEAT_PERIOD - 1);

      logic [HOLD_W-1:0] hold_q, hold_d;
      logic              armed_q, armed_d;
      logic              rep_q, rep_d;

      // Hold counter runs only while the level stays high past the rise edge;
      // armed selects the first-delay versus the repeat-period target.
      always_comb begin
        hold_d  = '0;
        armed_d = 1'b0;
        rep_d   = 1'b0;
        if (pressed_d && !ch_rise_d) begin
          armed_d = armed_q;
          if (hold_q == (armed_q ? NEXT_LAST : FIRST_LAST)) begin
            rep_d   = 1'b1;
            armed_d = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end

      // Register hold counter state and the repeat pulse.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          hold_q  <= '0;
          armed_q <= 1'b0;
          rep_q   <= 1'b0;
        end else begin
          hold_q  <= hold_d;
          armed_q <= armed_d;
          rep_q   <= rep_d;
        end
      end

      assign repeat_pulse[gi] = rep_q;
`else
      assign repeat_pulse[gi] = 1'b0;
`endif
    end
  endgenerate

  // Aggregate edge flag, registered so it lines up with the per-channel pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      any_edge_q <= 1'b0;
    end else begin
      any_edge_q <= |(rise_d | fall_d);
    end
  end

  assign any_edge = any_edge_q;

endmodule

// File: tb/tb_debounce_edge_multi.sv
// Scoreboard bench for debounce_edge_multi (4 channels, delay 8, KEY on bit 3).
// Stimulus pushes expected edge/repeat events with hand-computed cycle numbers;
// a negedge monitor pops and compares whenever the DUT presents a pulse.
module tb_debounce_edge_multi;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] button = 4'b1000;
  logic [3:0] button_pressed, rise_pulse, fall_pulse, repeat_pulse;
  logic       any_edge;

  always #10 clk = ~clk;

  debounce_edge_multi #(
    .NUM_SWITCHES   (4),
    .DELAY_COUNTS   (8),
    .SYNC_STAGES    (2),
    .ACTIVE_LOW_MASK(4'b1000),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .button        (button),
    .button_pressed(button_pressed),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .repeat_pulse  (repeat_pulse),
    .any_edge      (any_edge)
  );

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] level;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } rep_t;

  ev_t        eq[$];
  rep_t       rq[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic       mon_en = 1'b0;
  logic [3:0] mon_level = 4'b0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] l);
    ev_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.level = l;
    eq.push_back(e);
  endtask

  task automatic push_rep(input int c, input logic [3:0] m);
    rep_t r;
    r.cyc = c; r.mask = m;
    rq.push_back(r);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compares DUT pulses against the scoreboard queues every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      logic edge_seen;
      edge_seen = (rise_pulse != 4'b0) || (fall_pulse != 4'b0) || any_edge;
      if (eq.size() == 0) begin
        check("edge_idle", {23'b0, rise_pulse, fall_pulse, any_edge}, 32'b0);
        check("level_hold", {28'b0, button_pressed}, {28'b0, mon_level});
      end else if (edge_seen || eq[0].cyc <= cyc) begin
        ev_t e;
        e = eq.pop_front();
        check("edge_cycle", cyc, e.cyc);
        check("rise_pulse", {28'b0, rise_pulse}, {28'b0, e.rise});
        check("fall_pulse", {28'b0, fall_pulse}, {28'b0, e.fall});
        check("any_edge",   {31'b0, any_edge},   32'b1);
        check("level_new",  {28'b0, button_pressed}, {28'b0, e.level});
        mon_level = e.level;
      end else begin
        check("level_hold", {28'b0, button_pressed}, {28'b0, mon_level});
      end

      if (rq.size() == 0) begin
        check("repeat_idle", {28'b0, repeat_pulse}, 32'b0);
      end else if (repeat_pulse != 4'b0 || rq[0].cyc <= cyc) begin
        rep_t r;
        r = rq.pop_front();
        check("repeat_cycle", cyc, r.cyc);
        check("repeat_mask", {28'b0, repeat_pulse}, {28'b0, r.mask});
      end
    end
  end

  // Directed stimulus. Inputs change on negedge after cycle c, so the flip is
  // visible at monitor cycle c+10 (2 sync stages + 8 debounce cycles).
  initial begin
    int c;
    reset_n = 1'b0;
    button  = 4'b1000;
    wait_cyc(5);
    check("rst_level",  {28'b0, button_pressed}, 32'b0);
    check("rst_rise",   {28'b0, rise_pulse},     32'b0);
    check("rst_fall",   {28'b0, fall_pulse},     32'b0);
    check("rst_repeat", {28'b0, repeat_pulse},   32'b0);
    check("rst_any",    {31'b0, any_edge},       32'b0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    wait_cyc(30);
    check("idle_level", {28'b0, button_pressed}, 32'b0);

    // Clean press and release on channel 0.
    button[0] = 1'b1; push_ev(cyc + 10, 4'b0001, 4'b0000, 4'b0001); wait_cyc(15);
    button[0] = 1'b0; push_ev(cyc + 10, 4'b0000, 4'b0001, 4'b0000); wait_cyc(15);

    // Bounce on channel 1: 3-cycle toggles for 40 cycles, then settle high.
    for (int t = 0; t < 40; t++) begin
      button[1] = ((t / 3) % 2 == 0);
      @(negedge clk);
    end
    button[1] = 1'b1; push_ev(cyc + 10, 4'b0010, 4'b0000, 4'b0010); wait_cyc(15);
    button[1] = 1'b0; push_ev(cyc + 10, 4'b0000, 4'b0010, 4'b0000); wait_cyc(15);

    // Boundary on channel 2: 7-cycle pulse is rejected, 8-cycle pulse flips.
    button[2] = 1'b1; wait_cyc(7);
    button[2] = 1'b0; wait_cyc(15);
    c = cyc;
    button[2] = 1'b1; push_ev(c + 10, 4'b0100, 4'b0000, 4'b0100); wait_cyc(8);
    button[2] = 1'b0; push_ev(c + 18, 4'b0000, 4'b0100, 4'b0000); wait_cyc(15);

    // Active-low KEY on channel 3.
    button[3] = 1'b0; push_ev(cyc + 10, 4'b1000, 4'b0000, 4'b1000); wait_cyc(15);
    button[3] = 1'b1; push_ev(cyc + 10, 4'b0000, 4'b1000, 4'b0000); wait_cyc(15);

    // Simultaneous rise and fall on channels 0 and 2.
    button = 4'b1101; push_ev(cyc + 10, 4'b0101, 4'b0000, 4'b0101); wait_cyc(15);
    button = 4'b1000; push_ev(cyc + 10, 4'b0000, 4'b0101, 4'b0000); wait_cyc(15);

    // Reset at debounce count 4 on channel 1, then a full delay after release.
    button[1] = 1'b1; wait_cyc(6);
    reset_n = 1'b0; wait_cyc(2);
    reset_n = 1'b1; push_ev(cyc + 10, 4'b0010, 4'b0000, 4'b0010); wait_cyc(15);
    button[1] = 1'b0; push_ev(cyc + 10, 4'b0000, 4'b0010, 4'b0000); wait_cyc(15);

    // Long hold on channel 0: repeats at +20/+25/+30 only with the feature.
    c = cyc;
    button[0] = 1'b1; push_ev(c + 10, 4'b0001, 4'b0000, 4'b0001);
`ifdef DEBOUNCE_REPEAT_EN
    push_rep(c + 30, 4'b0001);
    push_rep(c + 35, 4'b0001);
    push_rep(c + 40, 4'b0001);
`endif
    wait_cyc(32);
    button[0] = 1'b0; push_ev(cyc + 10, 4'b0000, 4'b0001, 4'b0000); wait_cyc(20);

    check("edge_queue_drained",   eq.size(), 32'd0);
    check("repeat_queue_drained", rq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
